// File: rtl/ram_pkg.sv
// Shared definitions for the single-port RAM family: read-during-write policy
// codes, the clear-sequencer state type and an address-width helper.
package ram_pkg;

   // Read-during-write policy codes for the RDW_MODE parameter.
   localparam int unsigned RDW_READ_FIRST  = 0;
   localparam int unsigned RDW_WRITE_FIRST = 1;
   localparam int unsigned RDW_NO_CHANGE   = 2;

   // Clear-sequencer states: INIT zero-fills the array, READY serves accesses.
   typedef enum logic [0:0] {
      StInit  = 1'b0,
      StReady = 1'b1
   } ram_state_e;

   // Address width for a given depth; never below 1 so a 1-word RAM still has a port.
   function automatic int unsigned addr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer for ram_sp_param. Walks the address space once,
// one word per cycle, requesting zero writes, then parks in READY. When
// CLEAR_ON_RST is 0 it resets straight into READY and never requests a write.
module ram_clear_seq
   import ram_pkg::*;
#(
   parameter int unsigned DEPTH        = 16,
   parameter int unsigned ADDR_W       = addr_width(DEPTH),
   parameter bit          CLEAR_ON_RST = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   output logic              init_busy,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr
);

   localparam ram_state_e        RstState = CLEAR_ON_RST ? StInit : StReady;
   localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

   ram_state_e        state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;

   // State and counter register; reset restarts the clear from address 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RstState;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: leave INIT on the cycle that writes the last address.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StInit: begin
            if (cnt_q == LastAddr) begin
               state_d = StReady;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + ADDR_W'(1);
            end
         end
         StReady: begin
            state_d = StReady;
         end
         default: begin
            state_d = RstState;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs: busy and clear-write request are both just "in INIT".
   always_comb begin
      init_busy = (state_q == StInit);
      clr_we    = (state_q == StInit);
      clr_addr  = cnt_q;
   end

endmodule

// File: rtl/ram_sp_param.sv
// Parametrised single-port synchronous RAM with byte enables, selectable
// read-during-write policy, read-valid flag and optional post-reset clear.
// Optional feature macro: RAM_SP_OUTREG_EN adds a second output register
// stage (read latency 2); without it the read latency is 1.
module ram_sp_param
   import ram_pkg::*;
#(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned DEPTH        = 16,
   parameter int unsigned ADDR_W       = addr_width(DEPTH),
   parameter int unsigned RDW_MODE     = RDW_READ_FIRST,
   parameter bit          CLEAR_ON_RST = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                we,
   input  logic [DATA_W/8-1:0] be,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [DATA_W-1:0]   din,
   output logic [DATA_W-1:0]   dout,
   output logic                dout_vld,
   output logic                init_busy
);

   localparam int unsigned     NumBytes = DATA_W / 8;
   localparam logic [ADDR_W:0] DepthW   = (ADDR_W + 1)'(DEPTH);

   // Elaboration-time sanity checks on the configuration.
   if ((DATA_W % 8) != 0 || DATA_W == 0) begin : g_bad_width
      $error("ram_sp_param: DATA_W must be a non-zero multiple of 8");
   end
   if (RDW_MODE > RDW_NO_CHANGE) begin : g_bad_rdw
      $error("ram_sp_param: unknown RDW_MODE");
   end
   if (DEPTH == 0) begin : g_bad_depth
      $error("ram_sp_param: DEPTH must be at least 1");
   end

   logic [DATA_W-1:0] mem [DEPTH];

   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;

   logic              acc;
   logic              in_range;
   logic [DATA_W-1:0] rd_word;
   logic [DATA_W-1:0] merged;

   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   logic [DATA_W-1:0] s1_dout_q, s1_dout_d;
   logic              s1_vld_q, s1_vld_d;

   ram_clear_seq #(
      .DEPTH        (DEPTH),
      .ADDR_W       (ADDR_W),
      .CLEAR_ON_RST (CLEAR_ON_RST)
   ) u_clear_seq (
      .clk       (clk),
      .rst       (rst),
      .init_busy (init_busy),
      .clr_we    (clr_we),
      .clr_addr  (clr_addr)
   );

   // Access qualification and the old word at addr; out-of-range reads as 0.
   always_comb begin
      acc      = en && !init_busy;
      in_range = ({1'b0, addr} < DepthW);
      rd_word  = '0;
      if (in_range) begin
         rd_word = mem[addr];
      end
   end

   // Byte merge: enabled lanes take din, the rest keep the old word.
   always_comb begin
      merged = rd_word;
      for (int i = 0; i < NumBytes; i++) begin
         if (be[i]) begin
            merged[8*i +: 8] = din[8*i +: 8];
         end
      end
   end

   // Array write mux: the clear sequencer owns the port while it runs.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = addr;
      wr_data = merged;
      if (clr_we) begin
         wr_en   = 1'b1;
         wr_addr = clr_addr;
         wr_data = '0;
      end else if (acc && we && in_range) begin
         wr_en = 1'b1;
      end
   end

   // Array storage; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_en && !rst) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // First output stage next-state: read data and valid per the RDW policy.
   always_comb begin
      s1_dout_d = s1_dout_q;
      s1_vld_d  = 1'b0;
      if (acc) begin
         if (!we) begin
            s1_dout_d = rd_word;
            s1_vld_d  = 1'b1;
         end else if (RDW_MODE == RDW_READ_FIRST) begin
            s1_dout_d = rd_word;
            s1_vld_d  = 1'b1;
         end else if (RDW_MODE == RDW_WRITE_FIRST) begin
            // A dropped out-of-range write still reads back as 0.
            s1_dout_d = in_range ? merged : '0;
            s1_vld_d  = 1'b1;
         end else begin
            s1_dout_d = s1_dout_q;
            s1_vld_d  = 1'b0;
         end
      end
   end

   // First output stage register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_dout_q <= '0;
         s1_vld_q  <= 1'b0;
      end else begin
         s1_dout_q <= s1_dout_d;
         s1_vld_q  <= s1_vld_d;
      end
   end

`ifdef RAM_SP_OUTREG_EN
   logic [DATA_W-1:0] s2_dout_q;
   logic              s2_vld_q;

   // Second output stage: pure delay, so holds and valids propagate as-is.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_dout_q <= '0;
         s2_vld_q  <= 1'b0;
      end else begin
         s2_dout_q <= s1_dout_q;
         s2_vld_q  <= s1_vld_q;
      end
   end

   assign dout     = s2_dout_q;
   assign dout_vld = s2_vld_q;
`else
   assign dout     = s1_dout_q;
   assign dout_vld = s1_vld_q;
`endif

endmodule

// File: tb/tb_ram_sp_param.sv
// Directed self-checking bench for ram_sp_param. Four instances cover the
// three read-during-write policies, a non-power-of-two depth and the
// no-clear configuration. Latency follows RAM_SP_OUTREG_EN.
module tb_ram_sp_param;
   import ram_pkg::*;

`ifdef RAM_SP_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clk;
   logic        rst;
   logic        en       [4];
   logic        we       [4];
   logic [3:0]  be       [4];
   logic [3:0]  addr     [4];
   logic [31:0] din      [4];
   logic [31:0] dout     [4];
   logic        dout_vld [4];
   logic        init_busy[4];

   int n_checks;
   int n_pass;

   // 0: read-first, 1: write-first, 2: no-change depth 12, 3: no clear
   ram_sp_param #(.DATA_W(32), .DEPTH(16), .RDW_MODE(RDW_READ_FIRST), .CLEAR_ON_RST(1'b1)) u_rf (
      .clk(clk), .rst(rst), .en(en[0]), .we(we[0]), .be(be[0]), .addr(addr[0]), .din(din[0]),
      .dout(dout[0]), .dout_vld(dout_vld[0]), .init_busy(init_busy[0]));
   ram_sp_param #(.DATA_W(32), .DEPTH(16), .RDW_MODE(RDW_WRITE_FIRST), .CLEAR_ON_RST(1'b1)) u_wf (
      .clk(clk), .rst(rst), .en(en[1]), .we(we[1]), .be(be[1]), .addr(addr[1]), .din(din[1]),
      .dout(dout[1]), .dout_vld(dout_vld[1]), .init_busy(init_busy[1]));
   ram_sp_param #(.DATA_W(32), .DEPTH(12), .RDW_MODE(RDW_NO_CHANGE), .CLEAR_ON_RST(1'b1)) u_nc (
      .clk(clk), .rst(rst), .en(en[2]), .we(we[2]), .be(be[2]), .addr(addr[2]), .din(din[2]),
      .dout(dout[2]), .dout_vld(dout_vld[2]), .init_busy(init_busy[2]));
   ram_sp_param #(.DATA_W(32), .DEPTH(16), .RDW_MODE(RDW_READ_FIRST), .CLEAR_ON_RST(1'b0)) u_ncl (
      .clk(clk), .rst(rst), .en(en[3]), .we(we[3]), .be(be[3]), .addr(addr[3]), .din(din[3]),
      .dout(dout[3]), .dout_vld(dout_vld[3]), .init_busy(init_busy[3]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
   endtask

   // One access on instance k, then wait out the read latency and sample.
   task automatic do_op(input int k, input bit w, input logic [3:0] b, input logic [3:0] a,
                        input logic [31:0] d, output logic [31:0] q, output logic v);
      @(negedge clk);
      en[k] = 1'b1; we[k] = w; be[k] = b; addr[k] = a; din[k] = d;
      @(negedge clk);
      en[k] = 1'b0; we[k] = 1'b0;
      repeat (LAT - 1) @(negedge clk);
      q = dout[k];
      v = dout_vld[k];
   endtask

   // Cycles until init_busy of instance k drops, bounded.
   task automatic count_busy(input int k, output int n);
      n = 0;
      while (init_busy[k] && n < 100) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      logic [31:0] q;
      logic        v;
      int          n;
      int          n2;
      logic        seen_vld;
      logic [31:0] sq [6];
      logic        sv [6];

      n_checks = 0;
      n_pass   = 0;
      rst      = 1'b1;
      for (int k = 0; k < 4; k++) begin
         en[k] = 1'b0; we[k] = 1'b0; be[k] = 4'h0; addr[k] = 4'h0; din[k] = 32'h0;
      end

      // Reset values
      #1;
      check("rst_busy_rf", {31'b0, init_busy[0]}, 32'd1);
      check("rst_busy_nc", {31'b0, init_busy[2]}, 32'd1);
      check("rst_busy_noclr", {31'b0, init_busy[3]}, 32'd0);
      check("rst_dout", dout[0], 32'h0);
      check("rst_vld", {31'b0, dout_vld[0]}, 32'd0);

      // Clear sequence with a write attempted on instance 0 during INIT
      repeat (2) @(negedge clk);
      rst = 1'b0;
      n = 0; n2 = 0; seen_vld = 1'b0;
      while (init_busy[0] && n < 100) begin
         en[0] = (n < 10); we[0] = 1'b1; be[0] = 4'hf; addr[0] = 4'd5; din[0] = 32'hffff_ffff;
         seen_vld = seen_vld | dout_vld[0];
         if (init_busy[2]) n2++;
         @(negedge clk);
         n++;
      end
      en[0] = 1'b0; we[0] = 1'b0;
      check("init_cycles_16", n, 32'd16);
      check("init_cycles_12", n2, 32'd12);
      check("init_vld_low", {31'b0, seen_vld}, 32'd0);

      for (int a = 0; a < 16; a++) begin
         do_op(0, 1'b0, 4'h0, 4'(a), 32'h0, q, v);
         check("clear_read", q, 32'h0);
      end
      check("clear_read_vld", {31'b0, v}, 32'd1);

      // Byte enables
      do_op(1, 1'b1, 4'b1111, 4'd2, 32'hAABB_CCDD, q, v);
      do_op(1, 1'b1, 4'b0101, 4'd2, 32'h1122_3344, q, v);
      check("be_wf_merged", q, 32'hAA22_CC44);
      do_op(1, 1'b0, 4'h0, 4'd2, 32'h0, q, v);
      check("be_read", q, 32'hAA22_CC44);
      check("be_read_vld", {31'b0, v}, 32'd1);

      // Read-during-write: read-first
      do_op(0, 1'b1, 4'hf, 4'd3, 32'h55, q, v);
      do_op(0, 1'b1, 4'hf, 4'd3, 32'h9A, q, v);
      check("rdw_rf_dout", q, 32'h55);
      check("rdw_rf_vld", {31'b0, v}, 32'd1);
      do_op(0, 1'b0, 4'h0, 4'd3, 32'h0, q, v);
      check("rdw_rf_after", q, 32'h9A);
      do_op(0, 1'b1, 4'h0, 4'd3, 32'h77, q, v);
      check("be0_rf_dout", q, 32'h9A);
      check("be0_rf_vld", {31'b0, v}, 32'd1);
      do_op(0, 1'b0, 4'h0, 4'd3, 32'h0, q, v);
      check("be0_unchanged", q, 32'h9A);

      // Read-during-write: write-first
      do_op(1, 1'b1, 4'hf, 4'd3, 32'h55, q, v);
      do_op(1, 1'b1, 4'hf, 4'd3, 32'h9A, q, v);
      check("rdw_wf_dout", q, 32'h9A);
      check("rdw_wf_vld", {31'b0, v}, 32'd1);

      // Read-during-write: no-change
      do_op(2, 1'b1, 4'hf, 4'd3, 32'h55, q, v);
      do_op(2, 1'b0, 4'h0, 4'd3, 32'h0, q, v);
      check("nc_read", q, 32'h55);
      do_op(2, 1'b1, 4'hf, 4'd3, 32'h9A, q, v);
      check("rdw_nc_hold", q, 32'h55);
      check("rdw_nc_vld", {31'b0, v}, 32'd0);
      do_op(2, 1'b0, 4'h0, 4'd3, 32'h0, q, v);
      check("rdw_nc_after", q, 32'h9A);

      // Out of range on the depth-12 instance
      do_op(2, 1'b1, 4'hf, 4'd1, 32'h11, q, v);
      do_op(2, 1'b1, 4'hf, 4'd13, 32'hFF, q, v);
      do_op(2, 1'b0, 4'h0, 4'd13, 32'h0, q, v);
      check("oor_read", q, 32'h0);
      check("oor_vld", {31'b0, v}, 32'd1);
      do_op(2, 1'b0, 4'h0, 4'd1, 32'h0, q, v);
      check("oor_addr1", q, 32'h11);
      do_op(2, 1'b0, 4'h0, 4'd11, 32'h0, q, v);
      check("last_addr_read", q, 32'h0);
      do_op(2, 1'b0, 4'h0, 4'd12, 32'h0, q, v);
      check("depth_addr_vld", {31'b0, v}, 32'd1);

      // No-clear instance: ready from reset, plain write then read
      do_op(3, 1'b1, 4'hf, 4'd7, 32'hDEAD_BEEF, q, v);
      do_op(3, 1'b0, 4'h0, 4'd7, 32'h0, q, v);
      check("noclr_read", q, 32'hDEAD_BEEF);
      check("noclr_busy", {31'b0, init_busy[3]}, 32'd0);

      // Back-to-back reads
      do_op(1, 1'b1, 4'hf, 4'd0, 32'h10, q, v);
      do_op(1, 1'b1, 4'hf, 4'd1, 32'h20, q, v);
      do_op(1, 1'b1, 4'hf, 4'd2, 32'h30, q, v);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         sq[i] = dout[1];
         sv[i] = dout_vld[1];
         if (i < 3) begin
            en[1] = 1'b1; we[1] = 1'b0; addr[1] = 4'(i);
         end else begin
            en[1] = 1'b0;
         end
      end
      check("b2b_vld_before", {31'b0, sv[LAT-1]}, 32'd0);
      check("b2b_d0", sq[LAT], 32'h10);
      check("b2b_d1", sq[LAT+1], 32'h20);
      check("b2b_d2", sq[LAT+2], 32'h30);
      check("b2b_vld_run", {29'b0, sv[LAT], sv[LAT+1], sv[LAT+2]}, 32'd7);
      check("b2b_vld_after", {31'b0, sv[LAT+3]}, 32'd0);

      // Hold with en low, after seeding addr 10 for the restart test
      do_op(0, 1'b1, 4'hf, 4'd10, 32'h5A, q, v);
      do_op(0, 1'b0, 4'h0, 4'd3, 32'h0, q, v);
      repeat (2) @(negedge clk);
      check("hold_dout", dout[0], 32'h9A);
      check("hold_vld", {31'b0, dout_vld[0]}, 32'd0);

      // Reset mid-init
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_again_dout", dout[0], 32'h0);
      check("rst_again_busy", {31'b0, init_busy[0]}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      repeat (7) @(negedge clk);
      check("mid_init_busy", {31'b0, init_busy[0]}, 32'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_dout", dout[0], 32'h0);
      check("mid_rst_vld", {31'b0, dout_vld[0]}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      count_busy(0, n);
      check("restart_cycles", n, 32'd16);
      do_op(0, 1'b0, 4'h0, 4'd10, 32'h0, q, v);
      check("restart_clears_10", q, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ram_sp_param.md
# ram_sp_param

Parametrised single-port synchronous block RAM, the general-purpose successor to the fixed 16x8 RAM. It adds configurable width and depth, byte write enables, a selectable read-during-write policy, a read-valid flag, and an optional post-reset clear sequencer. It is used as the storage primitive under buffers and register files throughout the memory subsystem.

## Interface
- DATA_W, 8, word width in bits; must be a multiple of 8
- DEPTH, 16, number of words; need not be a power of two
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden
- RDW_MODE, RDW_READ_FIRST, read-during-write policy: RDW_READ_FIRST, RDW_WRITE_FIRST or RDW_NO_CHANGE
- CLEAR_ON_RST, 1, when 1 the block zero-fills the array after reset

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  access enable
- we  in  1  write enable; qualified by en
- be  in  DATA_W/8  byte enables; be[i] covers din[8i+7:8i]
- addr  in  ADDR_W  word address
- din  in  DATA_W  write data
- dout  out  DATA_W  read data, registered
- dout_vld  out  1  dout updated by a read this cycle
- init_busy  out  1  clear sequence running; all accesses ignored

## Operation
- Reset values: dout=0, dout_vld=0, init_busy=CLEAR_ON_RST. The array contents are not reset.
- FSM states:
  - INIT: entered on reset when CLEAR_ON_RST=1. Writes 0 to address cnt, where cnt runs 0..DEPTH-1 at one word per cycle. Moves to READY after DEPTH-1 is written.
  - READY: entered directly when CLEAR_ON_RST=0.
- Asserting rst mid-INIT restarts the clear from address 0.
- In INIT, en/we are ignored, dout holds and dout_vld=0.
- Access in READY with en=1:
  - we=1: write din bytes where be=1; bytes with be=0 keep their old value.
  - we=1 with be=0: no memory change; the read side follows RDW_MODE.
- Read-during-write (en=1, we=1):
  - READ_FIRST: dout = old word, dout_vld=1.
  - WRITE_FIRST: dout = merged new word (old bytes where be=0), dout_vld=1.
  - NO_CHANGE: dout holds, dout_vld=0.
- Read (en=1, we=0): dout = mem[addr], dout_vld=1.
- en=0: dout holds its last value, dout_vld=0.
- Out-of-range address (addr ≥ DEPTH): writes are dropped; reads return 0 with dout_vld=1.

## Timing
- Read latency is 1 cycle: dout and dout_vld are valid after the edge following the en sample. With RAM_SP_OUTREG_EN the latency is 2.
- Back-to-back accesses are allowed every cycle; throughput is one access per cycle.
- A write at edge N is visible to a read sampled at edge N+1 in every mode.
- INIT takes exactly DEPTH cycles after rst deasserts. init_busy falls on the edge that writes address DEPTH-1, so the first accepted access is sampled on the next edge.
- Deasserting rst is synchronised by the consuming logic; the block requires no extra sync.

## Configuration
- RAM_SP_OUTREG_EN defined:
  - Adds a second output register stage, for timing closure on large arrays.
  - dout and dout_vld are delayed by one further cycle; read latency is 2.
  - The pipeline stage resets to 0/0.
  - In NO_CHANGE mode, a hold propagates through the stage, so dout_vld=0 two cycles later.
- Undefined: single output register, latency 1.

## Structure
- Shared package ram_pkg holds:
  - RDW_READ_FIRST=0, RDW_WRITE_FIRST=1, RDW_NO_CHANGE=2 as localparams/enum.
  - The FSM state typedef (INIT, READY).
- Sub-module ram_clear_seq contains the INIT/READY FSM and address counter. It outputs init_busy, clr_we and clr_addr to the array write mux.
- The array, byte-merge and output pipeline stay in ram_sp_param.

## Test plan
- **Clear:** CLEAR_ON_RST=1, DEPTH=16, release rst.
  - init_busy is high 16 cycles.
  - A subsequent read of each address returns 0x00.
  - A write attempted during INIT has no effect.
- **Byte enables:** DATA_W=32.
  - Write 0xAABBCCDD with be=4'b1111, then 0x11223344 with be=4'b0101, then read.
  - dout=0xAA22CC44, dout_vld=1 one cycle after the read.
- **Read-during-write:** mem[3]=0x55, then en=we=1, addr=3, din=0x9A.
  - READ_FIRST: dout=0x55.
  - WRITE_FIRST: dout=0x9A.
  - NO_CHANGE: dout unchanged, dout_vld=0.
- **Reset mid-init:** pulse rst when the counter is at 7.
  - The counter restarts at 0; init_busy stays high 16 more cycles.
  - dout=0, dout_vld=0.
- **Out of range:** DEPTH=12, write 0xFF to addr 13, read addr 13.
  - dout=0, dout_vld=1.
  - Address 1 is unchanged.
- **RAM_SP_OUTREG_EN:** back-to-back reads of addrs 0,1,2 holding 0x10,0x20,0x30.
  - dout_vld rises 2 cycles after the first read.
  - Data appears in order 0x10,0x20,0x30 on consecutive cycles.
